sgen_nco_sweep_ctrl: RTL and testbench
======================================

// Module: sgen_nco_sweep_ctrl
// PURPOSE
//   Sequencer for sgen_nco: produces the frequency control word and NCO enable for linear
//   frequency sweeps (single, sawtooth, triangle) with a programmable dwell per step.
//   Sits between the register/config interface and sgen_nco i_fcw/i_ena.
// PARAMETERS
//   gp_phase_accu_width  16  FCW width; must equal the NCO phase-accumulator width
//   gp_dwell_width       16  width of the dwell counter
// PORTS
//   i_clk        in   1       clock
//   i_rst_an     in   1       reset, synchronous, active-low
//   i_start      in   1       start pulse; sampled only in IDLE
//   i_abort      in   1       abort; stops the sweep from any state
//   i_mode       in   2       00 single up, 01 sawtooth, 10 triangle, 11 treated as 00
//   i_fcw_start  in   W       first FCW of the sweep (W = gp_phase_accu_width)
//   i_fcw_stop   in   W       upper FCW bound (inclusive)
//   i_fcw_step   in   W       FCW increment per step
//   i_dwell      in   gp_dwell_width  each FCW value is held i_dwell+1 cycles
//   o_fcw        out  W       to sgen_nco i_fcw
//   o_ena        out  1       to sgen_nco i_ena
//   o_busy       out  1       high while a sweep is running
//   o_done       out  1       one-cycle pulse at single-sweep completion
//   o_step_tick  out  1       one-cycle pulse whenever o_fcw changes to the next step value
// BEHAVIOUR
//   - Reset (i_rst_an=0 at a clock edge): o_fcw=0, o_ena=0, o_busy=0, o_done=0, o_step_tick=0, state IDLE.
//     Applies mid-sweep with no exceptions.
//   - States: IDLE, RUN_UP, RUN_DOWN.
//   - IDLE + i_start & ~i_abort: latch mode/start/stop/step/dwell. On the next edge: o_fcw=start,
//     o_ena=1, o_busy=1, dwell cnt=i_dwell, state RUN_UP. Latency is 1 cycle.
//   - Config inputs are ignored while busy. i_start while busy is ignored.
//   - Dwell: the counter decrements each cycle; the step decision is taken when cnt==0.
//     The counter then reloads the latched dwell value.
//   - RUN_UP step: nxt = o_fcw + step, computed W+1 wide.
//     If no carry and nxt <= stop: o_fcw=nxt and o_step_tick=1. Otherwise this is the end of the up-ramp:
//       single   -> IDLE; o_done=1 for one cycle; o_ena=0, o_fcw=0, o_busy=0 on the same edge
//       sawtooth -> o_fcw=start, o_step_tick=1, remain RUN_UP
//       triangle -> RUN_DOWN and apply the down step immediately, subject to the down check
//   - RUN_DOWN step: nxt = o_fcw - step.
//     If no borrow and nxt >= start: o_fcw=nxt and o_step_tick=1. Otherwise -> RUN_UP and apply the up step.
//     Each endpoint is held for exactly one dwell per turn; it is never doubled.
//   - Degenerate triangle (both up and down checks fail, e.g. step=0 or start>=stop): o_fcw holds
//     start; no o_step_tick is issued.
//   - step=0 or start>=stop in single mode: start is held for one dwell, then done.
//     In sawtooth mode, start is held indefinitely with an o_step_tick at each dwell end.
//   - i_abort in any state: next edge IDLE, o_ena=0, o_fcw=0, o_busy=0, no o_done.
//     Abort wins over start and over a coincident dwell end.
//   - All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//   - sgen_nco_pkg holds:
//     - typedef enum logic [1:0] sweep_state_t {IDLE, RUN_UP, RUN_DOWN}
//     - localparams MODE_SINGLE=2'b00, MODE_SAW=2'b01, MODE_TRI=2'b10
//   - Sub-module sgen_nco_dwell_cnt: loadable down-counter with a zero flag, parameter gp_dwell_width.
//   - Top-level integration instantiates sgen_nco_sweep_ctrl and drives sgen_nco from o_fcw/o_ena.
// TESTING  (W=16; cycle 0 = first edge after i_start)
//   1 single: start=100 stop=130 step=10 dwell=2
//     -> o_fcw 100,110,120,130 for 3 cycles each; o_done pulse after cycle 11; o_ena=0 after.
//   2 non-aligned stop: start=100 stop=125 step=10 dwell=0
//     -> 100,110,120, then done; 130 never appears.
//   3 triangle: start=0 stop=20 step=10 dwell=0
//     -> 0,10,20,10,0,10,20 repeating; o_step_tick on every cycle; never done.
//   4 overflow: start=16'hFFF0 stop=16'hFFFF step=16'h0020 single dwell=3
//     -> 16'hFFF0 for 4 cycles, then done; no wrap to 16'h0010.
//   5 abort+restart: sawtooth sweep; i_abort at cycle 5 with i_start held high
//     -> next edge o_ena=0 o_fcw=0 o_busy=0, no o_done; an i_start during busy before the abort has no effect.
//   6 reset mid-sweep: i_rst_an=0 for 1 cycle at cycle 7
//     -> all outputs 0 on that edge; the block remains in IDLE until a fresh i_start.

Source files
------------

// File: rtl/sgen_nco_pkg.sv
// Shared types and constants for the NCO sweep sequencer.
package sgen_nco_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } sweep_state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

endpackage

// File: rtl/sgen_nco_dwell_cnt.sv
// Loadable down-counter with a zero flag; times how long each FCW value is held.
module sgen_nco_dwell_cnt #(
    parameter int gp_dwell_width = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_an,
    input  logic                      i_load,
    input  logic                      i_dec,
    input  logic [gp_dwell_width-1:0] i_load_val,
    output logic                      o_zero
);

    localparam logic [gp_dwell_width-1:0] ONE = gp_dwell_width'(1);

    logic [gp_dwell_width-1:0] cnt_reg;
    logic [gp_dwell_width-1:0] cnt_next;

    // Load has priority; decrement saturates at zero so an idle counter never wraps.
    always_comb begin
        cnt_next = cnt_reg;
        if (i_load) begin
            cnt_next = i_load_val;
        end else if (i_dec && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - ONE;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign o_zero = (cnt_reg == '0);

endmodule

// File: rtl/sgen_nco_sweep_ctrl.sv
// Sweep sequencer: generates FCW and enable for sgen_nco with single, sawtooth and
// triangle linear sweeps, each FCW value held for (dwell+1) cycles.
module sgen_nco_sweep_ctrl
    import sgen_nco_pkg::*;
#(
    parameter int gp_phase_accu_width = 16,
    parameter int gp_dwell_width      = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_an,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [1:0]                     i_mode,
    input  logic [gp_phase_accu_width-1:0] i_fcw_start,
    input  logic [gp_phase_accu_width-1:0] i_fcw_stop,
    input  logic [gp_phase_accu_width-1:0] i_fcw_step,
    input  logic [gp_dwell_width-1:0]      i_dwell,
    output logic [gp_phase_accu_width-1:0] o_fcw,
    output logic                           o_ena,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_step_tick
);

    localparam int W  = gp_phase_accu_width;
    localparam int DW = gp_dwell_width;

    sweep_state_t  state_reg;
    logic [1:0]    mode_reg;
    logic [W-1:0]  start_reg;
    logic [W-1:0]  stop_reg;
    logic [W-1:0]  step_reg;
    logic [DW-1:0] dwell_reg;
    logic [W-1:0]  fcw_reg;
    logic          ena_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          tick_reg;

    logic [W:0]    up_sum;
    logic [W:0]    dn_diff;
    logic          up_ok;
    logic          dn_ok;
    logic          running;
    logic          accept;
    logic          cnt_zero;
    logic          cnt_load;
    logic          cnt_dec;
    logic [DW-1:0] cnt_load_val;

    // Candidate next values one bit wider so carry/borrow is visible; a zero step
    // never counts as a valid step, which makes step=0 behave like a degenerate range.
    always_comb begin
        up_sum  = {1'b0, fcw_reg} + {1'b0, step_reg};
        dn_diff = {1'b0, fcw_reg} - {1'b0, step_reg};
        up_ok   = (step_reg != '0) && !up_sum[W]  && (up_sum[W-1:0]  <= stop_reg);
        dn_ok   = (step_reg != '0) && !dn_diff[W] && (dn_diff[W-1:0] >= start_reg);
    end

    // Dwell counter control: first load takes the live input, reloads use the latched copy.
    always_comb begin
        running      = (state_reg != IDLE);
        accept       = (state_reg == IDLE) && i_start && !i_abort;
        cnt_load     = accept || (running && cnt_zero && !i_abort);
        cnt_dec      = running && !cnt_zero;
        cnt_load_val = accept ? i_dwell : dwell_reg;
    end

    sgen_nco_dwell_cnt #(
        .gp_dwell_width (DW)
    ) u_dwell_cnt (
        .i_clk      (i_clk),
        .i_rst_an   (i_rst_an),
        .i_load     (cnt_load),
        .i_dec      (cnt_dec),
        .i_load_val (cnt_load_val),
        .o_zero     (cnt_zero)
    );

    // Sweep FSM with registered outputs; abort overrides everything except reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            state_reg <= IDLE;
            mode_reg  <= MODE_SINGLE;
            start_reg <= '0;
            stop_reg  <= '0;
            step_reg  <= '0;
            dwell_reg <= '0;
            fcw_reg   <= '0;
            ena_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            tick_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            tick_reg <= 1'b0;
            if (i_abort) begin
                state_reg <= IDLE;
                fcw_reg   <= '0;
                ena_reg   <= 1'b0;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (i_start) begin
                            mode_reg  <= i_mode;
                            start_reg <= i_fcw_start;
                            stop_reg  <= i_fcw_stop;
                            step_reg  <= i_fcw_step;
                            dwell_reg <= i_dwell;
                            fcw_reg   <= i_fcw_start;
                            ena_reg   <= 1'b1;
                            busy_reg  <= 1'b1;
                            state_reg <= RUN_UP;
                        end
                    end
                    RUN_UP: begin
                        if (cnt_zero) begin
                            if (up_ok) begin
                                fcw_reg  <= up_sum[W-1:0];
                                tick_reg <= 1'b1;
                            end else begin
                                case (mode_reg)
                                    MODE_SAW: begin
                                        fcw_reg  <= start_reg;
                                        tick_reg <= 1'b1;
                                    end
                                    MODE_TRI: begin
                                        // Turn at the top; if the down step is also
                                        // impossible the range is degenerate, so hold.
                                        if (dn_ok) begin
                                            fcw_reg   <= dn_diff[W-1:0];
                                            tick_reg  <= 1'b1;
                                            state_reg <= RUN_DOWN;
                                        end
                                    end
                                    default: begin
                                        // Single sweep (mode 11 included) ends here.
                                        state_reg <= IDLE;
                                        fcw_reg   <= '0;
                                        ena_reg   <= 1'b0;
                                        busy_reg  <= 1'b0;
                                        done_reg  <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    RUN_DOWN: begin
                        if (cnt_zero) begin
                            if (dn_ok) begin
                                fcw_reg  <= dn_diff[W-1:0];
                                tick_reg <= 1'b1;
                            end else begin
                                // Turn at the bottom and take the up step in the same
                                // cycle so the endpoint is held only one dwell.
                                state_reg <= RUN_UP;
                                if (up_ok) begin
                                    fcw_reg  <= up_sum[W-1:0];
                                    tick_reg <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_fcw       = fcw_reg;
    assign o_ena       = ena_reg;
    assign o_busy      = busy_reg;
    assign o_done      = done_reg;
    assign o_step_tick = tick_reg;

endmodule

// File: tb/tb_sgen_nco_sweep_ctrl.sv
// Bench for sgen_nco_sweep_ctrl: cycle-by-cycle model comparison plus directed
// literal expectations for each sweep scenario.
module tb_sgen_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_an;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] fcw_start;
    logic [15:0] fcw_stop;
    logic [15:0] fcw_step;
    logic [15:0] dwell;
    logic [15:0] fcw;
    logic        ena;
    logic        busy;
    logic        done;
    logic        tick;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state (plain integers).
    bit m_busy = 0;
    int m_dir  = 1;
    int m_left = 0;
    int m_fcw  = 0;
    int m_start, m_stop, m_step, m_dwell, m_mode;
    int e_fcw = 0, e_ena = 0, e_busy = 0, e_done = 0, e_tick = 0;

    always #5 clk = ~clk;

    sgen_nco_sweep_ctrl #(
        .gp_phase_accu_width (16),
        .gp_dwell_width      (16)
    ) dut (
        .i_clk       (clk),
        .i_rst_an    (rst_an),
        .i_start     (start),
        .i_abort     (abort),
        .i_mode      (mode),
        .i_fcw_start (fcw_start),
        .i_fcw_stop  (fcw_stop),
        .i_fcw_step  (fcw_step),
        .i_dwell     (dwell),
        .o_fcw       (fcw),
        .o_ena       (ena),
        .o_busy      (busy),
        .o_done      (done),
        .o_step_tick (tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: what the outputs must be after each edge, from the sweep rules.
    task automatic model_edge();
        bit up_ok, dn_ok;
        e_done = 0;
        e_tick = 0;
        if (!rst_an) begin
            m_busy = 0;
            m_fcw  = 0;
        end else if (abort) begin
            m_busy = 0;
            m_fcw  = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_start = fcw_start; m_stop = fcw_stop; m_step = fcw_step;
                m_dwell = dwell;     m_mode = mode;
                m_fcw   = m_start;   m_busy = 1; m_dir = 1; m_left = m_dwell;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            m_left = m_dwell;
            up_ok = (m_step > 0) && (m_fcw + m_step <= m_stop);
            dn_ok = (m_step > 0) && (m_fcw - m_step >= m_start);
            if (m_dir > 0) begin
                if (up_ok) begin
                    m_fcw += m_step; e_tick = 1;
                end else if (m_mode == 1) begin
                    m_fcw = m_start; e_tick = 1;
                end else if (m_mode == 2) begin
                    if (dn_ok) begin
                        m_fcw -= m_step; e_tick = 1; m_dir = -1;
                    end
                end else begin
                    m_busy = 0; m_fcw = 0; e_done = 1;
                end
            end else begin
                if (dn_ok) begin
                    m_fcw -= m_step; e_tick = 1;
                end else begin
                    m_dir = 1;
                    if (up_ok) begin
                        m_fcw += m_step; e_tick = 1;
                    end
                end
            end
        end
        e_fcw  = m_fcw;
        e_ena  = m_busy;
        e_busy = m_busy;
    endtask

    // Compare process: every cycle, DUT against the model, #1 after the edge.
    initial begin
        forever begin
            @(posedge clk);
            model_edge();
            #1;
            chk("cmp_fcw",  32'(fcw),  32'(e_fcw));
            chk("cmp_ena",  32'(ena),  32'(e_ena));
            chk("cmp_busy", 32'(busy), 32'(e_busy));
            chk("cmp_done", 32'(done), 32'(e_done));
            chk("cmp_tick", 32'(tick), 32'(e_tick));
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Pulse start for one edge; returns at the negedge right after cycle 0.
    task automatic start_sweep(input logic [1:0] md, input logic [15:0] s, input logic [15:0] p,
                               input logic [15:0] st, input logic [15:0] dw);
        @(negedge clk);
        mode = md; fcw_start = s; fcw_stop = p; fcw_step = st; dwell = dw;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    int tri_seq [9] = '{0, 10, 20, 10, 0, 10, 20, 10, 0};

    initial begin
        rst_an = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
        fcw_start = '0; fcw_stop = '0; fcw_step = '0; dwell = '0;
        repeat (2) @(negedge clk);
        chk("rst_fcw",  32'(fcw),  0);
        chk("rst_ena",  32'(ena),  0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tick", 32'(tick), 0);
        rst_an = 1'b1;
        $display("reset: outputs idle");

        // 1: single sweep, dwell 2.
        start_sweep(2'b00, 16'd100, 16'd130, 16'd10, 16'd2);
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t1_fcw_c%0d", k), 32'(fcw), (k < 12) ? 100 + 10 * (k / 3) : 0);
            if (k == 0)  chk("t1_ena_c0", 32'(ena), 1);
            if (k == 3)  chk("t1_tick_c3", 32'(tick), 1);
            if (k == 4)  chk("t1_tick_c4", 32'(tick), 0);
            if (k == 11) chk("t1_done_c11", 32'(done), 0);
            if (k == 12) begin
                chk("t1_done_c12", 32'(done), 1);
                chk("t1_ena_c12",  32'(ena),  0);
                chk("t1_busy_c12", 32'(busy), 0);
            end
            if (k == 13) chk("t1_done_c13", 32'(done), 0);
        end
        $display("test1: single 100..130 step 10 dwell 2");

        // 2: stop not on a step boundary.
        start_sweep(2'b00, 16'd100, 16'd125, 16'd10, 16'd0);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t2_fcw_c%0d", k), 32'(fcw), (k < 3) ? 100 + 10 * k : 0);
        end
        chk("t2_done_c3", 32'(done), 1);
        $display("test2: single non-aligned stop 125");

        // 3: triangle.
        start_sweep(2'b10, 16'd0, 16'd20, 16'd10, 16'd0);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t3_fcw_c%0d", k), 32'(fcw), tri_seq[k]);
            if (k > 0) chk($sformatf("t3_tick_c%0d", k), 32'(tick), 1);
        end
        do_abort();
        chk("t3_abort_busy", 32'(busy), 0);
        $display("test3: triangle 0..20 step 10");

        // 4: up step would overflow the accumulator width.
        start_sweep(2'b00, 16'hFFF0, 16'hFFFF, 16'h0020, 16'd3);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t4_fcw_c%0d", k), 32'(fcw), (k < 4) ? 32'h0000FFF0 : 0);
        end
        chk("t4_done_c4", 32'(done), 1);
        $display("test4: overflow guard at 0xFFF0");

        // 5: sawtooth, ignored start while busy, abort with start held.
        start_sweep(2'b01, 16'd10, 16'd30, 16'd10, 16'd0);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t5_fcw_c%0d", k), 32'(fcw), 10 + 10 * (k % 3));
            if (k == 1) begin
                start = 1'b1; fcw_start = 16'd500; fcw_stop = 16'd900; fcw_step = 16'd1;
            end
            if (k == 2) start = 1'b0;
            if (k == 4) begin
                abort = 1'b1; start = 1'b1;
            end
        end
        @(negedge clk);
        chk("t5_abort_fcw",  32'(fcw),  0);
        chk("t5_abort_ena",  32'(ena),  0);
        chk("t5_abort_busy", 32'(busy), 0);
        chk("t5_abort_done", 32'(done), 0);
        @(negedge clk);
        chk("t5_abort_hold_busy", 32'(busy), 0);
        abort = 1'b0; start = 1'b0;
        $display("test5: sawtooth abort with start held");

        // 6: reset in the middle of a sweep.
        start_sweep(2'b00, 16'd100, 16'd200, 16'd10, 16'd1);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t6_fcw_c%0d", k), 32'(fcw), 100 + 10 * (k / 2));
        end
        rst_an = 1'b0;
        @(negedge clk);
        rst_an = 1'b1;
        chk("t6_rst_fcw",  32'(fcw),  0);
        chk("t6_rst_ena",  32'(ena),  0);
        chk("t6_rst_busy", 32'(busy), 0);
        repeat (4) @(negedge clk);
        chk("t6_idle_busy", 32'(busy), 0);
        chk("t6_idle_fcw",  32'(fcw),  0);
        start_sweep(2'b00, 16'd40, 16'd60, 16'd10, 16'd0);
        chk("t6_restart_fcw", 32'(fcw), 40);
        chk("t6_restart_ena", 32'(ena), 1);
        repeat (5) @(negedge clk);
        $display("test6: reset mid-sweep then restart");

        // 7: degenerate triangle with step 0.
        start_sweep(2'b10, 16'd50, 16'd100, 16'd0, 16'd1);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t7_fcw_c%0d", k), 32'(fcw), 50);
            chk($sformatf("t7_tick_c%0d", k), 32'(tick), 0);
        end
        do_abort();
        $display("test7: degenerate triangle step 0");

        // 8: sawtooth with step 0 ticks at every dwell end.
        start_sweep(2'b01, 16'd7, 16'd100, 16'd0, 16'd1);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t8_fcw_c%0d", k), 32'(fcw), 7);
            chk($sformatf("t8_tick_c%0d", k), 32'(tick), (k == 2 || k == 4) ? 1 : 0);
        end
        do_abort();
        $display("test8: sawtooth step 0");

        // 9: mode 11 behaves as single.
        start_sweep(2'b11, 16'd0, 16'd5, 16'd5, 16'd0);
        for (int k = 0; k <= 2; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t9_fcw_c%0d", k), 32'(fcw), (k < 2) ? 5 * k : 0);
        end
        chk("t9_done_c2", 32'(done), 1);
        $display("test9: mode 11 as single");

        // 10: triangle with start above stop holds start.
        start_sweep(2'b10, 16'd30, 16'd20, 16'd5, 16'd0);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t10_fcw_c%0d", k), 32'(fcw), 30);
        end
        do_abort();
        $display("test10: triangle start above stop");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
